// File: rtl/nn_vec_loader.sv
// Word-pair to vector assembler: gathers N (x, w) pairs into packed buses
// using two ping-pong banks so one vector fills while the other is held.
module nn_vec_loader #(
    parameter int N  = 8,
    parameter int W  = 17,
    parameter int CW = 16
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [W-1:0]   in_x,
    input  logic [W-1:0]   in_w,
    input  logic           in_last,
    output logic           vec_valid,
    input  logic           vec_ready,
    output logic [W*N-1:0] x_bus,
    output logic [W*N-1:0] w_bus,
    output logic           err_short,
    output logic [CW-1:0]  vec_cnt
);

    localparam int CNTW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CNTW-1:0] LAST_IDX = CNTW'(N - 1);

    logic [W-1:0]    xs [2][N];
    logic [W-1:0]    ws [2][N];
    logic [1:0]      full;
    logic            fsel;
    logic            osel;
    logic [CNTW-1:0] cnt;
    logic            acc;
    logic            rel;
    logic            close_vec;

    // Readiness depends only on registered state; held low during reset.
    assign in_ready  = !rst && !full[fsel];
    assign vec_valid = full[osel];
    assign acc       = in_valid && in_ready;
    assign rel       = vec_valid && vec_ready;
    assign close_vec = (cnt == LAST_IDX) || in_last;

    always_comb begin
        x_bus = '0;
        w_bus = '0;
        for (int unsigned k = 0; k < N; k++) begin
            x_bus[W*k +: W] = xs[osel][k];
            w_bus[W*k +: W] = ws[osel][k];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned b = 0; b < 2; b++) begin
                for (int unsigned k = 0; k < N; k++) begin
                    xs[b][k] <= '0;
                    ws[b][k] <= '0;
                end
            end
            full      <= '0;
            fsel      <= 1'b0;
            osel      <= 1'b0;
            cnt       <= '0;
            err_short <= 1'b0;
            vec_cnt   <= '0;
        end else begin
            if (acc) begin
                // Early last zero-pads the tail so the dot product ignores it.
                for (int unsigned k = 0; k < N; k++) begin
                    if (CNTW'(k) == cnt) begin
                        xs[fsel][k] <= in_x;
                        ws[fsel][k] <= in_w;
                    end else if (in_last && (CNTW'(k) > cnt)) begin
                        xs[fsel][k] <= '0;
                        ws[fsel][k] <= '0;
                    end
                end
                if (close_vec) begin
                    full[fsel] <= 1'b1;
                    fsel       <= ~fsel;
                    cnt        <= '0;
                    if (cnt != LAST_IDX) begin
                        err_short <= 1'b1;
                    end
                end else begin
                    cnt <= cnt + CNTW'(1);
                end
            end
            // fsel != osel whenever both fire, so the full[] writes never collide.
            if (rel) begin
                full[osel] <= 1'b0;
                osel       <= ~osel;
                vec_cnt    <= vec_cnt + CW'(1);
            end
        end
    end

endmodule
